// File: rtl/mem_req_arbiter_if.sv
// Boundary bundle of the shared memory port arbiter: instruction and data
// requester ports plus the SRAM-like port toward the AXI bridge.
interface mem_req_arbiter_if;
  logic        inst_sram_req;
  logic [1:0]  inst_sram_size;
  logic [31:0] inst_sram_addr;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;

  logic        data_sram_req;
  logic        data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic        data_sram_addr_ok;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;

  logic        mem_req;
  logic        mem_wr;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_addr_ok;
  logic        mem_data_ok;
  logic [31:0] mem_rdata;

  // Arbiter side
  modport slave (
    input  inst_sram_req, inst_sram_size, inst_sram_addr,
    output inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
    input  data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb,
    input  data_sram_addr, data_sram_wdata,
    output data_sram_addr_ok, data_sram_data_ok, data_sram_rdata,
    output mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata,
    input  mem_addr_ok, mem_data_ok, mem_rdata
  );

  // Pipeline requesters and memory bridge side
  modport master (
    output inst_sram_req, inst_sram_size, inst_sram_addr,
    input  inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
    output data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb,
    output data_sram_addr, data_sram_wdata,
    input  data_sram_addr_ok, data_sram_data_ok, data_sram_rdata,
    input  mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata,
    output mem_addr_ok, mem_data_ok, mem_rdata
  );
endinterface

// File: rtl/mem_req_arbiter.sv
// Arbitrates fetch and EXE requests onto one SRAM-like port and routes
// in-order responses back through a tag FIFO of request owners.
module mem_req_arbiter #(
  parameter int unsigned MAX_OUT      = 4,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  mem_req_arbiter_if.slave          bus,
  output logic [$clog2(MAX_OUT):0]  outstanding
);
  localparam int unsigned PTR_W = $clog2(MAX_OUT);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned STV_W = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_LOCK_I, ST_LOCK_D} state_e;
  typedef enum logic {OWN_I = 1'b0, OWN_D = 1'b1} owner_e;

  state_e             state_q, state_d;
  owner_e             grant_c;
  logic               mem_req_c;
  logic               accept_c;
  logic               pop_c;
  logic               head_c;
  logic               full_c;
  logic               starve_max_c;
  logic [STV_W-1:0]   starve_q, starve_d;
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [MAX_OUT-1:0] tag_q;

  assign full_c       = (cnt_q == CNT_W'(MAX_OUT));
  assign starve_max_c = (starve_q == STV_W'(STARVE_LIMIT));

  // Grant selection, lock tracking and starvation counter
  always_comb begin
    grant_c   = OWN_I;
    mem_req_c = 1'b0;
    state_d   = state_q;
    starve_d  = starve_q;

    case (state_q)
      ST_LOCK_I: begin
        grant_c   = OWN_I;
        mem_req_c = bus.inst_sram_req;
      end
      ST_LOCK_D: begin
        grant_c   = OWN_D;
        mem_req_c = bus.data_sram_req;
      end
      default: begin
        if (bus.data_sram_req && !(starve_max_c && bus.inst_sram_req)) begin
          grant_c   = OWN_D;
          mem_req_c = 1'b1;
        end else if (bus.inst_sram_req) begin
          grant_c   = OWN_I;
          mem_req_c = 1'b1;
        end
      end
    endcase

    // A full tag FIFO blocks issue even if a response frees a slot this cycle
    mem_req_c = mem_req_c && !full_c && !reset;
    accept_c  = mem_req_c && bus.mem_addr_ok;

    if (mem_req_c && !bus.mem_addr_ok) begin
      state_d = (grant_c == OWN_D) ? ST_LOCK_D : ST_LOCK_I;
    end else if (accept_c) begin
      state_d = ST_IDLE;
    end

    if (!bus.inst_sram_req || (accept_c && grant_c == OWN_I)) begin
      starve_d = '0;
    end else if (accept_c && grant_c == OWN_D && !starve_max_c) begin
      starve_d = starve_q + STV_W'(1);
    end
  end

  assign bus.mem_req   = mem_req_c;
  assign bus.mem_wr    = (grant_c == OWN_D) && bus.data_sram_wr;
  assign bus.mem_size  = (grant_c == OWN_D) ? bus.data_sram_size : bus.inst_sram_size;
  assign bus.mem_addr  = (grant_c == OWN_D) ? bus.data_sram_addr : bus.inst_sram_addr;
  assign bus.mem_wstrb = (grant_c == OWN_D) ? bus.data_sram_wstrb : 4'h0;
  assign bus.mem_wdata = (grant_c == OWN_D) ? bus.data_sram_wdata : 32'h0;

  assign bus.inst_sram_addr_ok = accept_c && (grant_c == OWN_I);
  assign bus.data_sram_addr_ok = accept_c && (grant_c == OWN_D);

  // Responses are routed by the head tag sampled before any same-cycle push
  assign head_c = tag_q[rd_ptr_q];
  assign pop_c  = bus.mem_data_ok && (cnt_q != '0) && !reset;
  assign cnt_d  = cnt_q + CNT_W'(accept_c) - CNT_W'(pop_c);

  assign bus.inst_sram_data_ok = pop_c && (head_c == OWN_I);
  assign bus.data_sram_data_ok = pop_c && (head_c == OWN_D);
  assign bus.inst_sram_rdata   = bus.mem_rdata;
  assign bus.data_sram_rdata   = bus.mem_rdata;

  assign outstanding = cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      starve_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      cnt_q    <= cnt_d;
      if (accept_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_c)    rd_ptr_q <= rd_ptr_q + PTR_W'(1);
    end
  end

  // Owner tags need no reset: entries are only read after being written
  always_ff @(posedge clk) begin
    if (accept_c) tag_q[wr_ptr_q] <= grant_c;
  end
endmodule

// File: doc/mem_req_arbiter.md
Name: mem_req_arbiter

Overview:
Shares one SRAM-like memory port between the fetch-stage instruction requester (read-only) and the EXE-stage data requester (load/store). It sits between the pipeline and the AXI bridge. It arbitrates requests, holds the grant until the address handshake completes, and tracks outstanding transactions in an in-order tag FIFO so each data_ok/rdata is routed back to the requester that issued it.

Parameters:
MAX_OUT, 4, maximum accepted-but-unanswered transactions (power of two, >=2)
STARVE_LIMIT, 4, consecutive data grants allowed while inst_sram_req is pending before instruction side is forced

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
inst_sram_req  in  1  instruction read request
inst_sram_size  in  2  0=byte,1=half,2=word
inst_sram_addr  in  32  instruction physical address
inst_sram_addr_ok  out  1  instruction request accepted this cycle
inst_sram_data_ok  out  1  instruction read data valid
inst_sram_rdata  out  32  instruction read data
data_sram_req  in  1  data request
data_sram_wr  in  1  1=store
data_sram_size  in  2  access size
data_sram_wstrb  in  4  byte strobes (stores)
data_sram_addr  in  32  data physical address
data_sram_wdata  in  32  store data
data_sram_addr_ok  out  1  data request accepted this cycle
data_sram_data_ok  out  1  load data valid / store complete
data_sram_rdata  out  32  load data
mem_req  out  1  shared-port request
mem_wr  out  1  shared-port write (0 when inst granted)
mem_size  out  2  granted size
mem_wstrb  out  4  granted strobes (0 when inst granted)
mem_addr  out  32  granted address
mem_wdata  out  32  granted wdata (0 when inst granted)
mem_addr_ok  in  1  slave accepts mem_req this cycle
mem_data_ok  in  1  slave response, strictly in acceptance order
mem_rdata  in  32  slave response data
outstanding  out  $clog2(MAX_OUT)+1  current in-flight count

Behaviour:
- Accept = mem_req && mem_addr_ok. A requester's addr_ok = mem_addr_ok && mem_req && (grant == that requester). Both are combinational.
- Grant selection when not locked:
  - data wins if data_sram_req, unless starve_cnt == STARVE_LIMIT and inst_sram_req, in which case inst wins.
  - Otherwise inst wins if inst_sram_req.
  - Otherwise there is no request and mem_req = 0.
- Lock: if mem_req && !mem_addr_ok, a lock register holds the current owner. Grant stays on the locked owner, even if a higher-priority request appears, until that owner's accept. The lock clears on accept.
- starve_cnt update order:
  - Cleared on any inst accept, or in any cycle inst_sram_req = 0.
  - Otherwise incremented on a data accept, saturating at STARVE_LIMIT.
- Full: mem_req is forced to 0 when outstanding == MAX_OUT, even if mem_data_ok pops in the same cycle. The push waits one cycle.
- Tag FIFO (1-bit owner, depth MAX_OUT, circular pointers with wrap):
  - Push on accept; pop on mem_data_ok && outstanding != 0.
  - Simultaneous push and pop leaves the count unchanged.
- Response routing:
  - inst_sram_data_ok = mem_data_ok && nonempty && head == inst; data_sram_data_ok likewise for head == data.
  - Both rdata outputs pass mem_rdata through unconditionally.
  - mem_data_ok while empty is ignored and never forwarded.
- Combinational response: a response may arrive in the same cycle as a later accept; pop uses the head before the push.
- Reset values: outstanding 0, FIFO pointers 0, lock clear, starve_cnt 0. During reset, mem_req and all addr_ok/data_ok outputs are forced to 0.
- Reset mid-operation discards all in-flight tags. Late mem_data_ok after reset is ignored.

Test Plan:
1. data_sram_req load, addr 0x1C000100, size 2, mem_addr_ok=1 -> data_sram_addr_ok=1, outstanding=1. Next cycle mem_data_ok, rdata 0xDEADBEEF -> data_sram_data_ok=1, data_sram_rdata=0xDEADBEEF, inst_sram_data_ok=0, outstanding=0.
2. inst and data requests in the same cycle, addr_ok=1 -> data accepted in cycle 0, inst in cycle 1. Responses in order route D then I.
3. inst_sram_req with mem_addr_ok=0 for 3 cycles, data_sram_req rising in cycle 1 -> mem_addr stays the inst address, inst accepted in cycle 3, data accepted in cycle 4.
4. Both requests held high, addr_ok always 1, STARVE_LIMIT=4 -> grant sequence D,D,D,D,I,D,D,D,D,I.
5. MAX_OUT=2, two accepts with no data_ok -> mem_req=0 while requests are pending. mem_data_ok arrives -> mem_req stays 0 that cycle, accept happens next cycle, outstanding returns to 2.
6. Two outstanding (I,D), reset for 1 cycle, then mem_data_ok -> outstanding=0 and no data_ok is forwarded to either side.
